// File: rtl/counter_mem_pkg.sv
// counter_mem_pkg: shared types and helpers for the checkpoint counter
package counter_mem_pkg;
    typedef enum logic {RUN, CLEARED} state_t;
    typedef enum logic [2:0] {CMD_CLR, CMD_RSH, CMD_RES, CMD_CNT, CMD_HOLD} cmd_t;
    function automatic int sel_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
    function automatic cmd_t cmd_pick(input logic clr, input logic rsh, input logic res, input logic cnt);
        return clr ? CMD_CLR : rsh ? CMD_RSH : res ? CMD_RES : cnt ? CMD_CNT : CMD_HOLD;
    endfunction
endpackage

// File: rtl/checkpoint_slots.sv
// checkpoint_slots: snapshot register array, combinational read before the write lands
module checkpoint_slots
    import counter_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [sel_w(DEPTH)-1:0]   sel,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [DEPTH-1:0]          valid
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[sel];
    // data is never reset; valid bits gate every read
    always_ff @(posedge clk)
        if (we) mem[sel] <= wdata;
    always_ff @(posedge clk or negedge rst)
        if (!rst) valid <= '0;
        else if (we) valid[sel] <= 1'b1;
endmodule

// File: rtl/checkpoint_counter.sv
// checkpoint_counter: up/down modulo counter with snapshot slots and a shadow captured on clear
module checkpoint_counter
    import counter_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      clr,
    input  logic                      save,
    input  logic                      restore,
    input  logic                      restore_shadow,
    input  logic [sel_w(DEPTH)-1:0]   sel,
    output logic [WIDTH-1:0]          y,
    output logic                      wrap,
    output logic                      err,
    output logic [DEPTH-1:0]          slot_valid,
    output logic                      shadow_valid
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
    state_t state, state_n;
    cmd_t cmd;
    logic [WIDTH-1:0] shadow, rdata, y_n;
    logic wrap_n, err_n;
    checkpoint_slots #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_slots (
        .clk(clk), .rst(rst), .we(save), .sel(sel), .wdata(y), .rdata(rdata), .valid(slot_valid)
    );
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] v);
        return (v > TOP) ? TOP : v;
    endfunction
    // CLEARED suppresses only counting; restores and clr still apply
    always_comb begin
        cmd = cmd_pick(clr, restore_shadow, restore, en && state == RUN);
        y_n = y;
        wrap_n = 1'b0;
        err_n = 1'b0;
        state_n = clr ? CLEARED : RUN;
        case (cmd)
            CMD_CLR: y_n = '0;
            CMD_RSH: begin
                y_n = shadow_valid ? sat(shadow) : y;
                err_n = !shadow_valid;
            end
            CMD_RES: begin
                y_n = slot_valid[sel] ? sat(rdata) : y;
                err_n = !slot_valid[sel];
            end
            CMD_CNT: begin
                wrap_n = up ? (y == TOP) : (y == '0);
                y_n = up ? ((y == TOP) ? '0 : y + WIDTH'(1)) : ((y == '0) ? TOP : y - WIDTH'(1));
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            y <= '0;
            wrap <= 1'b0;
            err <= 1'b0;
            shadow <= '0;
            shadow_valid <= 1'b0;
            state <= RUN;
        end else begin
            y <= y_n;
            wrap <= wrap_n;
            err <= err_n;
            state <= state_n;
            if (clr) begin
                shadow <= y;
                shadow_valid <= 1'b1;
            end
        end
endmodule

// File: tb/tb_checkpoint_counter.sv
// tb_checkpoint_counter: directed stimulus, per-cycle model compare plus literal pins
module tb_checkpoint_counter;
    localparam int W = 4, D = 4, M = 9;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 0, up = 0, clr = 0, save = 0, restore = 0, restore_shadow = 0;
    logic [1:0] sel = 0;
    logic [W-1:0] y;
    logic wrap, err, shadow_valid;
    logic [D-1:0] slot_valid;
    int errors = 0, checks = 0;

    checkpoint_counter #(.WIDTH(W), .DEPTH(D), .MAX(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .save(save), .restore(restore),
        .restore_shadow(restore_shadow), .sel(sel), .y(y), .wrap(wrap), .err(err),
        .slot_valid(slot_valid), .shadow_valid(shadow_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int m_y, m_sh, m_slot [D];
    bit m_shv, m_hold, m_wrap, m_err;
    bit [D-1:0] m_sv;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_y = 0; m_sh = 0; m_shv = 0; m_hold = 0; m_wrap = 0; m_err = 0; m_sv = '0;
        end else begin
            int ny, old;
            bit nw, ne;
            old = m_y; ny = m_y; nw = 0; ne = 0;
            if (clr) begin
                m_sh = old; m_shv = 1; ny = 0;
            end else if (restore_shadow) begin
                if (m_shv) ny = (m_sh > M) ? M : m_sh; else ne = 1;
            end else if (restore) begin
                if (m_sv[sel]) ny = (m_slot[sel] > M) ? M : m_slot[sel]; else ne = 1;
            end else if (en && !m_hold) begin
                nw = up ? (old == M) : (old == 0);
                ny = up ? (old + 1) % (M + 1) : (old + M) % (M + 1);
            end
            if (save) begin
                m_slot[sel] = old; m_sv[sel] = 1;
            end
            m_hold = clr; m_y = ny; m_wrap = nw; m_err = ne;
        end
    end

    always @(negedge clk) begin
        chk("y", int'(y), m_y);
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("err", int'(err), int'(m_err));
        chk("slot_valid", int'(slot_valid), int'(m_sv));
        chk("shadow_valid", int'(shadow_valid), int'(m_shv));
    end

    task automatic step(input bit e, input bit u, input bit c, input bit s, input bit r, input bit rs, input logic [1:0] sl);
        @(negedge clk);
        en = e; up = u; clr = c; save = s; restore = r; restore_shadow = rs; sel = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(input int n, input bit u);
        for (int i = 0; i < n; i++) step(1, u, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int wraps;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_y", int'(y), 0);
        chk("reset_valid", int'(slot_valid), 0);
        chk("reset_shadow_valid", int'(shadow_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 0, 0, 0, 0, 0);
            if (wrap) wraps++;
            if (i == 9) chk("up_to_max", int'(y), 9);
            if (i == 10) chk("wrap_to_zero", int'(y) * 2 + int'(wrap), 1);
        end
        chk("up_12", int'(y), 2);
        chk("wrap_once", wraps, 1);
        cnt(2, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("down_wrap_y", int'(y), 9);
        chk("down_wrap_pulse", int'(wrap), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("down_after_wrap", int'(y) * 2 + int'(wrap), 16);
        cnt(9, 1);
        chk("count_to_7", int'(y), 7);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("clr_y", int'(y), 0);
        chk("clr_shadow_valid", int'(shadow_valid), 1);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("cleared_hold", int'(y), 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("count_resumes", int'(y), 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("restore_shadow", int'(y), 7);
        cnt(2, 0);
        step(1, 1, 0, 1, 0, 0, 2);
        chk("save_count_y", int'(y), 6);
        chk("save_valid", int'(slot_valid), 4);
        step(0, 0, 0, 0, 1, 0, 2);
        chk("restore_sel2", int'(y), 5);
        step(1, 1, 0, 0, 1, 0, 1);
        chk("restore_invalid_err", int'(err), 1);
        chk("restore_invalid_y", int'(y), 5);
        cnt(2, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        cnt(5, 1);
        chk("before_rbw", int'(y), 8);
        step(1, 1, 0, 1, 1, 0, 0);
        chk("rbw_y", int'(y), 3);
        chk("rbw_valid", int'(slot_valid), 5);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("rbw_slot0", int'(y), 8);
        cnt(8, 1);
        chk("before_reset", int'(y), 6);
        #3 rst = 1'b0;
        #1;
        chk("async_y", int'(y), 0);
        chk("async_valid", int'(slot_valid), 0);
        chk("async_shadow_valid", int'(shadow_valid), 0);
        @(negedge clk);
        en = 0; up = 0; clr = 0; save = 0; restore = 0; restore_shadow = 0; sel = 0;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 1, 0);
        chk("shadow_lost_err", int'(err), 1);
        chk("shadow_lost_y", int'(y), 0);
        cnt(3, 1);
        step(1, 1, 1, 0, 0, 1, 0);
        chk("clr_beats_rsh", int'(y) * 2 + int'(err), 0);
        step(1, 1, 0, 0, 0, 1, 0);
        chk("rsh_in_cleared", int'(y), 3);
        step(0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/checkpoint_counter.md
Name: checkpoint_counter

Overview:
Parametrised up/down modulo counter with a small checkpoint memory. Successor to the 4-bit counter with memory: adds width/modulus generics, direction control, DEPTH addressable snapshot slots, and an automatic shadow slot captured on soft clear so the count can be recovered. Sits as a reusable event/position counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter and slot data width in bits
DEPTH, 4, number of addressable snapshot slots (>=2, power of two)
MAX, 2**WIDTH-1, terminal count; counter range 0..MAX (MAX <= 2**WIDTH-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  count enable
up  in  1  direction: 1 increment, 0 decrement
clr  in  1  synchronous soft clear; memory retained, shadow captured
save  in  1  write current y into slot[sel]
restore  in  1  load y from slot[sel]
restore_shadow  in  1  load y from shadow slot
sel  in  $clog2(DEPTH)  slot index for save/restore
y  out  WIDTH  registered count
wrap  out  1  one-cycle pulse on modulo wrap
err  out  1  one-cycle pulse on restore from invalid slot
slot_valid  out  DEPTH  per-slot valid bits
shadow_valid  out  1  shadow slot holds a captured value

Behaviour:
- rst low (async): y=0, wrap=0, err=0, slot_valid=0, shadow_valid=0, shadow=0, FSM->RUN. Slot data not cleared (don't-care, gated by valid).
- All outputs registered; every command takes effect on the next rising edge (1-cycle latency).
- Command priority per cycle: clr > restore_shadow > restore > count. save is independent of those and always samples pre-update y.
- clr: shadow<=y, shadow_valid<=1, y<=0, FSM->CLEARED. No wrap.
- restore_shadow: if shadow_valid, y<=shadow; else err pulse, y unchanged.
- restore: if slot_valid[sel], y<=slot[sel]; else err pulse, y unchanged. Slot contents/valid unchanged.
- save: slot[sel]<=y (current, pre-increment), slot_valid[sel]<=1. save+restore same sel same cycle: slot written with old y, y loads old slot value (read-before-write).
- Count (en=1, no higher command): up: y==MAX -> y<=0, wrap=1; else y+1. down: y==0 -> y<=MAX, wrap=1; else y-1. en=0: hold.
- Any restored value > MAX is loaded as MAX (saturate, no err).
- FSM states: RUN (normal); CLEARED (entered by clr; y held at 0 for exactly one cycle regardless of en; restore/restore_shadow/clr still honoured); next cycle -> RUN. Counting resumes on second edge after clr.
- Reset mid-operation: async clear wins immediately; shadow lost by design (hard reset), soft clr is the recoverable path.
- wrap and err never both asserted in one cycle.

Decomposition:
- Package counter_mem_pkg: state_t enum {RUN, CLEARED}; localparam SEL_W = $clog2(DEPTH) helper function; cmd priority encoding enum.
- Sub-module checkpoint_slots: DEPTH x WIDTH register array with valid bits, one write port, one combinational read port, read-before-write semantics, async active-low reset of valid only.

Test Plan:
- WIDTH=4, MAX=9: rst released, en=1, up=1 for 12 cycles -> y 1..9,0,1,2; wrap pulses exactly once on 9->0.
- up=0 from y=0 -> y=9 with wrap=1; then y=8 next cycle.
- Count to 7, clr -> y=0 held 2 edges with en=1 (CLEARED), shadow_valid=1; restore_shadow -> y=7.
- save sel=2 at y=5 with en=1 -> y=6, slot_valid=4'b0100; later restore sel=2 -> y=5; restore sel=1 -> err=1, y unchanged.
- save sel=0 and restore sel=0 same cycle with slot0=3, y=8 -> y=3, slot0=8.
- Assert rst low mid-count at y=6 asynchronously (between edges) -> y=0, slot_valid=0, shadow_valid=0 immediately; restore_shadow after release -> err=1.
